fetch_queue: RTL and testbench

Instruction fetch front-end sitting directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and issues word requests to instruction memory over a request/grant, variable-latency response interface.
- Buffers returned {pc, instruction} pairs in a small queue and presents them to decode with a valid/ready handshake.
- Handles branch redirects by flushing the queue and discarding any in-flight stale response.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 53 +++++
 rtl/fetch_queue.sv | 105 ++++++++++
 tb/tb_fetch_queue.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package fetch_pkg;
  localparam int INSTR_W    = 32;
  localparam int ENTRY_PC_W = 64;

  // Decode inserts this bubble (addi x0,x0,0) whenever out_valid is low.
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {FETCH, WAIT, DRAIN} state_t;

  typedef struct packed {
    logic [ENTRY_PC_W-1:0] pc;
    logic [INSTR_W-1:0]    instr;
  } entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding {pc, instr} pairs; flush empties it in one cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 96
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: nothing reads an entry before it is written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/fetch_queue.sv
// Fetch front-end: owns the fetch PC, issues one request at a time, queues responses.
//   state | meaning
//   FETCH | no request outstanding; request fetch_pc when the queue has room
//   WAIT  | request granted; next response is pushed into the queue
//   DRAIN | request outstanding but made stale by a redirect; response is dropped
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               mem_req,
  output logic [PC_W-1:0]    mem_addr,
  input  logic               mem_gnt,
  input  logic               mem_rvalid,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = PC_W + INSTR_W;

  state_t          state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] req_pc_q, req_pc_d;
  logic            push, pop, flush, full, empty;
  logic [AW:0]     count;
  logic [EW-1:0]   head;

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(EW)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({req_pc_q, mem_rdata}),
    .pop       (pop),
    .flush     (flush),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    mem_req    = 1'b0;
    push       = 1'b0;
    flush      = 1'b0;
    if (redirect_valid) begin
      // A response landing in the redirect cycle belongs to the old path.
      flush      = 1'b1;
      fetch_pc_d = {redirect_pc[PC_W-1:2], 2'b00};
      if (state_q != FETCH) state_d = mem_rvalid ? FETCH : DRAIN;
    end else begin
      unique case (state_q)
        FETCH: begin
          mem_req = !reset && !full;
          if (mem_req && mem_gnt) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + PC_W'(4);
            state_d    = WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            push    = 1'b1;
            state_d = FETCH;
          end
        end
        DRAIN: begin
          if (mem_rvalid) state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  assign mem_addr  = fetch_pc_q;
  assign out_valid = !reset && (count != '0);
  assign pop       = out_valid && out_ready && !redirect_valid;
  assign out_pc    = empty ? '0 : head[EW-1:INSTR_W];
  assign out_instr = empty ? '0 : head[INSTR_W-1:0];
  assign busy      = !reset && (state_q != FETCH);
endmodule

// File: tb/tb_fetch_queue.sv
// Randomized scoreboard bench for fetch_queue: the bench plays instruction memory and IF/ID.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        busy;

  fetch_queue #(.DEPTH(DEPTH), .PC_W(64), .RESET_PC(64'h0)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_gnt        (mem_gnt),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_popped = 0;

  function automatic void check(input bit ok, input string name,
                                input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Reference model state
  entry_t      exp_q[$];
  logic [63:0] model_pc  = '0;
  logic [63:0] req_pc    = '0;
  bit          out_st    = 0;   // DUT has a request outstanding
  bit          stale     = 0;   // outstanding response must be dropped
  bit          mem_pend  = 0;   // bench memory owes a response
  int          mem_delay = 0;
  logic [31:0] resp_data = '0;
  int          q_size_now = 0;

  // Knobs
  bit          gnt_rand = 0, redir_en = 0, spur_en = 0, force_reset = 1, force_redir = 0;
  int          lat_max = 0, ready_mode = 1;
  logic [63:0] force_target = '0;

  // Monitor: compares the presented head against the scoreboard each cycle.
  always begin
    @(negedge clk);
    #1;
    if (reset) begin
      q_size_now = 0;
    end else begin
      q_size_now = exp_q.size();
      check(out_valid == (q_size_now != 0), "out_valid", 64'(out_valid), 64'(q_size_now != 0));
      if (out_valid && q_size_now != 0) begin
        check(out_pc == exp_q[0].pc, "out_pc", out_pc, exp_q[0].pc);
        check(out_instr == exp_q[0].instr, "out_instr", 64'(out_instr), 64'(exp_q[0].instr));
        if (out_ready && !redirect_valid) begin
          void'(exp_q.pop_front());
          n_popped++;
        end
      end else if (!out_valid) begin
        check(out_pc == '0 && out_instr == '0, "empty_head_zero", out_pc ^ 64'(out_instr), 64'h0);
      end
    end
  end

  task automatic cycle();
    bit drove_resp;
    @(negedge clk);
    reset = force_reset;
    redirect_valid = 1'b0;
    if (!force_reset) begin
      if (force_redir) begin
        redirect_valid = 1'b1;
        redirect_pc = force_target;
        force_redir = 0;
      end else if (redir_en && $urandom_range(15) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc = ($urandom_range(3) == 0) ? {32'hFFFF_FFFF, 28'hFFFF_FFF, 4'($urandom)}
                                               : {$urandom, $urandom};
      end
    end
    out_ready = (ready_mode == 2) ? 1'($urandom_range(1)) : (ready_mode == 1);
    mem_gnt = (mem_pend && !out_st) ? 1'b0 : (gnt_rand ? 1'($urandom_range(1)) : 1'b1);
    drove_resp = 0;
    mem_rdata = $urandom;
    if (mem_pend && mem_delay == 0) begin
      mem_rvalid = 1'b1;
      mem_rdata = resp_data;
      drove_resp = 1;
    end else if (mem_pend) begin
      mem_rvalid = 1'b0;
      mem_delay--;
    end else begin
      mem_rvalid = spur_en && ($urandom_range(7) == 0);
      mem_rdata = 32'hBADC_0DE5;
    end
    #2;
    if (reset) begin
      exp_q.delete();
      model_pc = '0;
      out_st = 0;
      stale = 0;
    end else begin
      check(mem_req == (!out_st && !redirect_valid && q_size_now < DEPTH), "mem_req",
            64'(mem_req), 64'(!out_st && !redirect_valid && q_size_now < DEPTH));
      check(busy == out_st, "busy", 64'(busy), 64'(out_st));
      if (mem_req) check(mem_addr == model_pc, "mem_addr", mem_addr, model_pc);
      if (mem_rvalid && out_st) begin
        out_st = 0;
        if (!stale && !redirect_valid) exp_q.push_back('{pc: req_pc, instr: mem_rdata});
        stale = 0;
      end
      if (redirect_valid) begin
        exp_q.delete();
        model_pc = {redirect_pc[63:2], 2'b00};
        if (out_st) stale = 1;
      end else if (mem_req && mem_gnt) begin
        req_pc = mem_addr;
        model_pc = model_pc + 64'd4;
        out_st = 1;
        stale = 0;
        mem_pend = 1;
        mem_delay = (lat_max == 0) ? 0 : $urandom_range(lat_max);
        resp_data = $urandom;
      end
    end
    if (drove_resp) mem_pend = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_outstanding();
    for (int i = 0; i < 50 && !out_st; i++) cycle();
    check(out_st, "wait_outstanding_timeout", 64'(out_st), 64'h1);
  endtask

  initial begin
    force_reset = 1;
    run(2);
    force_reset = 0;

    // Streaming at zero memory latency
    ready_mode = 1; lat_max = 0; gnt_rand = 0;
    run(30);
    // Back-pressure: queue fills, fetching stops, then drains
    ready_mode = 0; run(15);
    ready_mode = 1; run(15);

    // Redirect while a request is outstanding, target 0x100
    lat_max = 3;
    wait_outstanding();
    force_redir = 1; force_target = 64'h100;
    run(12);
    // Misaligned target is forced to word alignment
    wait_outstanding();
    force_redir = 1; force_target = 64'h103;
    run(12);
    // Fetch across the top of the address space
    force_redir = 1; force_target = 64'hFFFF_FFFF_FFFF_FFF4;
    run(20);

    // Fully random traffic
    gnt_rand = 1; ready_mode = 2; redir_en = 1; spur_en = 1;
    run(3000);

    // Reset while waiting with entries queued; late response must be ignored
    redir_en = 0; spur_en = 0; ready_mode = 0; gnt_rand = 0; lat_max = 3;
    for (int i = 0; i < 100 && !(exp_q.size() >= 3 && out_st); i++) cycle();
    check(exp_q.size() >= 3 && out_st, "prep_reset_in_wait", 64'(exp_q.size()), 64'd3);
    force_reset = 1; run(1);
    force_reset = 0;
    run(1);
    ready_mode = 2; gnt_rand = 1; redir_en = 1; spur_en = 1;
    run(300);

    check(n_popped >= 200, "delivery_progress", 64'(n_popped), 64'd200);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
